g_reg_wb_ctrl: RTL

Write-back controller and issue scoreboard for the general register file built from `g_reg_cell` instances. It shares the file's single write port between N_REQ functional-unit requesters using round-robin arbitration, and drives the per-cell `wb_i` strobes and write data. It also gates instruction issue: it raises `w_reserve_i` on the destination cell and stalls issue on RAW/WAW hazards read back from the cells' `w_reserve_o`. It sits between decode/issue and the execution units' result buses.

---
 rtl/g_reg_wb_ctrl_pkg.sv | 7 +
 rtl/g_reg_wb_ctrl_if.sv | 37 +++
 rtl/g_reg_wb_ctrl_arbiter.sv | 28 ++
 rtl/g_reg_wb_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/g_reg_wb_ctrl_pkg.sv
// Shared register-file parameters for the write-back controller slice.
package g_reg_wb_ctrl_pkg;
    localparam int DEF_W_OPR   = 32;
    localparam int DEF_N_REG   = 32;
    localparam int DEF_W_RADDR = 5;
    localparam int DEF_N_REQ   = 3;
endpackage

// File: rtl/g_reg_wb_ctrl_if.sv
// Issue, reservation and write-back bus between the controller and its neighbours.
interface g_reg_wb_ctrl_if
    import g_reg_wb_ctrl_pkg::*;
#(
    parameter int W_OPR   = DEF_W_OPR,
    parameter int N_REG   = DEF_N_REG,
    parameter int W_RADDR = DEF_W_RADDR,
    parameter int N_REQ   = DEF_N_REQ
);
    logic                     iss_valid_i;
    logic                     iss_rd_en_i;
    logic [W_RADDR-1:0]       iss_rd_i;
    logic [W_RADDR-1:0]       iss_rs1_i;
    logic [W_RADDR-1:0]       iss_rs2_i;
    logic                     iss_stall_o;
    logic [N_REG-1:0]         res_i;
    logic [N_REG-1:0]         w_reserve_o;
    logic [N_REQ-1:0]         req_valid_i;
    logic [N_REQ*W_RADDR-1:0] req_rd_i;
    logic [N_REQ*W_OPR-1:0]   req_data_i;
    logic [N_REQ-1:0]         req_ready_o;
    logic [N_REG-1:0]         wb_o;
    logic [W_OPR-1:0]         wb_data_o;
    logic                     wb_err_o;

    modport master (
        input  iss_valid_i, iss_rd_en_i, iss_rd_i, iss_rs1_i, iss_rs2_i,
        input  res_i, req_valid_i, req_rd_i, req_data_i,
        output iss_stall_o, w_reserve_o, req_ready_o, wb_o, wb_data_o, wb_err_o
    );

    modport slave (
        output iss_valid_i, iss_rd_en_i, iss_rd_i, iss_rs1_i, iss_rs2_i,
        output res_i, req_valid_i, req_rd_i, req_data_i,
        input  iss_stall_o, w_reserve_o, req_ready_o, wb_o, wb_data_o, wb_err_o
    );
endinterface

// File: rtl/g_reg_wb_ctrl_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last grant and wraps.
module g_rr_arbiter #(
    parameter int N     = 3,
    parameter int W_IDX = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [W_IDX-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             any
);
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W_IDX'(idx);
            end
        end
    end
endmodule

// File: rtl/g_reg_wb_ctrl.sv
// Write-back arbiter and issue scoreboard for the g_reg_cell register file:
// shares the single write port round-robin and gates issue on reserved cells.
module g_reg_wb_ctrl
    import g_reg_wb_ctrl_pkg::*;
#(
    parameter int W_OPR   = DEF_W_OPR,
    parameter int N_REG   = DEF_N_REG,
    parameter int W_RADDR = DEF_W_RADDR,
    parameter int N_REQ   = DEF_N_REQ
) (
    input logic            clk,
    input logic            reset,
    g_reg_wb_ctrl_if.master bus
);
    localparam int W_GIDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic               hazard;
    logic               iss_stall;
    logic [N_REG-1:0]   w_reserve;

    logic [N_REQ-1:0]   arb_req;
    logic [N_REQ-1:0]   gnt;
    logic [W_GIDX-1:0]  gnt_idx;
    logic               any;
    logic [W_RADDR-1:0] sel_rd;
    logic [W_OPR-1:0]   sel_data;

    logic [W_GIDX-1:0]  last_d,    last_q;
    logic               wb_vld_d,  wb_vld_q;
    logic [W_RADDR-1:0] wb_rd_d,   wb_rd_q;
    logic [W_OPR-1:0]   wb_data_d, wb_data_q;
    logic               wb_err_d,  wb_err_q;
    logic [N_REG-1:0]   wb;

    // Hazard reads cell reservation state only; the reserve strobe is suppressed in reset.
    always_comb begin
        hazard    = bus.res_i[bus.iss_rs1_i] | bus.res_i[bus.iss_rs2_i]
                  | (bus.iss_rd_en_i & bus.res_i[bus.iss_rd_i]);
        iss_stall = bus.iss_valid_i & hazard;
        w_reserve = '0;
        if (reset && bus.iss_valid_i && bus.iss_rd_en_i && !iss_stall)
            w_reserve[bus.iss_rd_i] = 1'b1;
    end

    assign arb_req = bus.req_valid_i & {N_REQ{reset}};

    g_rr_arbiter #(
        .N     (N_REQ),
        .W_IDX (W_GIDX)
    ) u_arb (
        .req     (arb_req),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_rd   = bus.req_rd_i[k*W_RADDR +: W_RADDR];
                sel_data = bus.req_data_i[k*W_OPR +: W_OPR];
            end
        end
    end

    always_comb begin
        last_d    = any ? gnt_idx : last_q;
        wb_vld_d  = any;
        wb_rd_d   = any ? sel_rd : wb_rd_q;
        wb_data_d = any ? sel_data : wb_data_q;
        wb_err_d  = wb_err_q | (any & ~bus.res_i[sel_rd]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q    <= W_GIDX'(N_REQ - 1);
            wb_vld_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            wb_vld_q  <= wb_vld_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    always_comb begin
        wb = '0;
        if (wb_vld_q)
            wb[wb_rd_q] = 1'b1;
    end

    assign bus.iss_stall_o = iss_stall;
    assign bus.w_reserve_o = w_reserve;
    assign bus.req_ready_o = gnt;
    assign bus.wb_o        = wb;
    assign bus.wb_data_o   = wb_data_q;
    assign bus.wb_err_o    = wb_err_q;
endmodule
